// File: rtl/ex_sequencer.sv
// Issue controller between decode and execute: buffers decoded instructions,
// launches them one at a time, holds results for MEM and handles branch flushes.
package ex_sequencer_pkg;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [4:0] rd;
    } control_s;

    function automatic control_s control_s_default();
        control_s c;
        c = '0;
        return c;
    endfunction

endpackage

module ex_sequencer
    import ex_sequencer_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_id_valid,
    output logic            o_id_ready,
    input  logic [XLEN-1:0] i_id_pc,
    input  control_s        i_id_control,
    input  logic [XLEN-1:0] i_id_rs1,
    input  logic [XLEN-1:0] i_id_rs2,
    input  logic [XLEN-1:0] i_id_imm,
    output logic            o_ex_start,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_rs1,
    output logic [XLEN-1:0] o_ex_rs2,
    output logic [XLEN-1:0] o_ex_imm,
    output control_s        o_ex_control,
    input  logic            i_ex_done,
    input  logic [XLEN-1:0] i_ex_rd_output,
    input  logic [XLEN-1:0] i_ex_pc_ext,
    input  logic            i_ex_pc_load,
    output logic            o_mem_valid,
    input  logic            i_mem_ready,
    output control_s        o_mem_control,
    output logic [XLEN-1:0] o_mem_rd_output,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_busy,
    output logic            o_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_HOLD      = 2'd3;

    logic [1:0]      state;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [WW-1:0]   watchdog;

    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [XLEN-1:0] fifo_rs1  [DEPTH];
    logic [XLEN-1:0] fifo_rs2  [DEPTH];
    logic [XLEN-1:0] fifo_imm  [DEPTH];
    control_s        fifo_ctrl [DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic flush;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_id_ready = !fifo_full;
    assign push       = i_id_valid && !fifo_full;
    assign pop        = (state == S_ISSUE);
    assign flush      = (state == S_WAIT_DONE) && i_ex_done && i_ex_pc_load;
    assign o_busy     = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_pc[wr_ptr[AW-1:0]]   <= i_id_pc;
            fifo_rs1[wr_ptr[AW-1:0]]  <= i_id_rs1;
            fifo_rs2[wr_ptr[AW-1:0]]  <= i_id_rs2;
            fifo_imm[wr_ptr[AW-1:0]]  <= i_id_imm;
            fifo_ctrl[wr_ptr[AW-1:0]] <= i_id_control;
        end
    end

    // A taken branch discards everything younger, including a same-cycle push.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= rd_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= S_IDLE;
            watchdog        <= '0;
            o_ex_start      <= 1'b0;
            o_ex_pc         <= '0;
            o_ex_rs1        <= '0;
            o_ex_rs2        <= '0;
            o_ex_imm        <= '0;
            o_ex_control    <= control_s_default();
            o_mem_valid     <= 1'b0;
            o_mem_control   <= control_s_default();
            o_mem_rd_output <= '0;
            o_redirect      <= 1'b0;
            o_redirect_pc   <= '0;
            o_error         <= 1'b0;
        end else begin
            o_ex_start <= 1'b0;
            o_redirect <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    o_ex_pc      <= fifo_pc[rd_ptr[AW-1:0]];
                    o_ex_rs1     <= fifo_rs1[rd_ptr[AW-1:0]];
                    o_ex_rs2     <= fifo_rs2[rd_ptr[AW-1:0]];
                    o_ex_imm     <= fifo_imm[rd_ptr[AW-1:0]];
                    o_ex_control <= fifo_ctrl[rd_ptr[AW-1:0]];
                    o_ex_start   <= 1'b1;
                    watchdog     <= '0;
                    state        <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (watchdog != WD_MAX) watchdog <= watchdog + 1'b1;
                    if (watchdog == WD_LAST) o_error <= 1'b1;
                    if (i_ex_done) begin
                        o_mem_control   <= o_ex_control;
                        o_mem_rd_output <= i_ex_rd_output;
                        o_mem_valid     <= 1'b1;
                        state           <= S_HOLD;
                        if (i_ex_pc_load) begin
                            o_redirect    <= 1'b1;
                            o_redirect_pc <= i_ex_pc_ext;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_mem_ready) begin
                        o_mem_valid <= 1'b0;
                        state       <= fifo_empty ? S_IDLE : S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_sequencer.sv
// Randomised and directed bench for ex_sequencer, checked against an
// in-order queue model of the instruction stream with an execute-unit stub.
module tb_ex_sequencer;
    import ex_sequencer_pkg::*;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        control_s    ctrl;
    } instr_t;

    logic            clk;
    logic            reset;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc, id_rs1, id_rs2, id_imm;
    control_s        id_control;
    logic            ex_start;
    logic [XLEN-1:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
    control_s        ex_control;
    logic            ex_done;
    logic [XLEN-1:0] ex_rd_output, ex_pc_ext;
    logic            ex_pc_load;
    logic            mem_valid;
    logic            mem_ready;
    control_s        mem_control;
    logic [XLEN-1:0] mem_rd_output;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;
    logic            error;

    ex_sequencer #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_id_valid(id_valid), .o_id_ready(id_ready), .i_id_pc(id_pc),
        .i_id_control(id_control), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_imm(id_imm),
        .o_ex_start(ex_start), .o_ex_pc(ex_pc), .o_ex_rs1(ex_rs1), .o_ex_rs2(ex_rs2),
        .o_ex_imm(ex_imm), .o_ex_control(ex_control),
        .i_ex_done(ex_done), .i_ex_rd_output(ex_rd_output), .i_ex_pc_ext(ex_pc_ext),
        .i_ex_pc_load(ex_pc_load),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_control(mem_control),
        .o_mem_rd_output(mem_rd_output),
        .o_redirect(redirect), .o_redirect_pc(redirect_pc), .o_busy(busy), .o_error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: instructions accepted but not yet issued, plus the one in execute
    instr_t      fifo_q[$];
    instr_t      inflight;
    bit          outstanding, waiting, mem_pending, exp_redirect, error_exp;
    logic [31:0] exp_rd, exp_redirect_pc;
    control_s    exp_ctrl;
    int          wd_edges, lat_cnt, exec_lat;
    bit          rand_lat, hold_done, spurious_en;
    int          redirect_count;
    logic [31:0] last_redirect_pc;
    logic [31:0] issued_pcs[$];
    logic [31:0] mem_log[$];

    function automatic logic [31:0] exec_result(instr_t i);
        return i.ctrl.alu_op[0] ? (i.rs1 ^ i.imm) : (i.rs1 + i.rs2);
    endfunction

    function automatic control_s rand_ctrl();
        control_s c;
        c.alu_op    = 4'($urandom);
        c.branch    = ($urandom_range(0, 3) == 0);
        c.jump      = 1'($urandom);
        c.mem_read  = 1'($urandom);
        c.mem_write = 1'($urandom);
        c.reg_write = 1'($urandom);
        c.rd        = 5'($urandom);
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock: note handshakes before the edge, update the model, check after it
    task automatic step();
        bit     rst_ev, push_ev, done_ev, accept_ev, flush_ev;
        instr_t pushed;
        rst_ev    = reset;
        push_ev   = id_valid && id_ready && !reset;
        done_ev   = ex_done && waiting && !reset;
        accept_ev = mem_valid && mem_ready && !reset;
        flush_ev  = done_ev && ex_pc_load;
        pushed    = '{id_pc, id_rs1, id_rs2, id_imm, id_control};
        if (accept_ev) mem_log.push_back(mem_rd_output);
        @(posedge clk);
        #1;
        if (rst_ev) begin
            fifo_q.delete();
            outstanding = 0; waiting = 0; mem_pending = 0;
            exp_redirect = 0; error_exp = 0; wd_edges = 0;
        end else begin
            if (waiting) begin
                wd_edges++;
                if (wd_edges == TIMEOUT) error_exp = 1;
            end
            if (accept_ev) begin
                outstanding = 0;
                mem_pending = 0;
            end
            if (done_ev) begin
                waiting     = 0;
                mem_pending = 1;
                exp_rd      = exec_result(inflight);
                exp_ctrl    = inflight.ctrl;
                if (flush_ev) begin
                    exp_redirect    = 1;
                    exp_redirect_pc = inflight.pc + inflight.imm;
                    fifo_q.delete();
                end
            end
            if (push_ev && !flush_ev) fifo_q.push_back(pushed);
        end

        if (ex_start) begin
            checkOutput("start_legal", 64'(!outstanding && fifo_q.size() > 0), 64'(1));
            if (fifo_q.size() > 0) begin
                inflight = fifo_q.pop_front();
                checkOutput("ex_pc", 64'(ex_pc), 64'(inflight.pc));
                checkOutput("ex_rs1", 64'(ex_rs1), 64'(inflight.rs1));
                checkOutput("ex_rs2", 64'(ex_rs2), 64'(inflight.rs2));
                checkOutput("ex_imm", 64'(ex_imm), 64'(inflight.imm));
                checkOutput("ex_control", 64'(ex_control), 64'(inflight.ctrl));
            end
            outstanding = 1;
            waiting     = 1;
            wd_edges    = 0;
            issued_pcs.push_back(ex_pc);
            lat_cnt = rand_lat ? int'($urandom_range(0, 3)) : exec_lat;
        end else if (waiting) begin
            checkOutput("ex_pc_stable", 64'(ex_pc), 64'(inflight.pc));
        end

        checkOutput("redirect", 64'(redirect), 64'(exp_redirect));
        if (exp_redirect) checkOutput("redirect_pc", 64'(redirect_pc), 64'(exp_redirect_pc));
        if (redirect) begin
            redirect_count++;
            last_redirect_pc = redirect_pc;
        end
        exp_redirect = 0;

        checkOutput("mem_valid", 64'(mem_valid), 64'(mem_pending));
        if (mem_pending) begin
            checkOutput("mem_rd_output", 64'(mem_rd_output), 64'(exp_rd));
            checkOutput("mem_control", 64'(mem_control), 64'(exp_ctrl));
        end
        checkOutput("id_ready", 64'(id_ready), 64'(fifo_q.size() < DEPTH));
        checkOutput("busy", 64'(busy), 64'(fifo_q.size() != 0 || outstanding));
        checkOutput("error", 64'(error), 64'(error_exp));

        // Execute-unit stub drives the next cycle
        ex_done      = 1'b0;
        ex_pc_load   = 1'($urandom);
        ex_rd_output = $urandom;
        ex_pc_ext    = $urandom;
        if (waiting && !hold_done) begin
            if (lat_cnt == 0) begin
                ex_done      = 1'b1;
                ex_rd_output = exec_result(inflight);
                ex_pc_load   = inflight.ctrl.branch;
                ex_pc_ext    = inflight.pc + inflight.imm;
            end else begin
                lat_cnt--;
            end
        end else if (!waiting && spurious_en) begin
            ex_done = ($urandom_range(0, 3) == 0);
        end
    endtask

    // Offer one instruction to the ID port until it is accepted
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input control_s c);
        bit accepted;
        accepted = 0;
        id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_imm = imm; id_control = c;
        for (int n = 0; n < 40 && !accepted; n++) begin
            accepted = id_ready;
            step();
        end
        id_valid = 1'b0;
        if (!accepted) checkOutput("offer_timeout", 64'(0), 64'(1));
    endtask

    // what: 0 = ex_start, 1 = mem_valid, 2 = not busy
    task automatic waitFor(input int what, input string tag, output int steps);
        bit hit;
        hit = 0;
        steps = 0;
        for (int n = 0; n < 80 && !hit; n++) begin
            step();
            steps++;
            case (what)
                0:       hit = ex_start;
                1:       hit = mem_valid;
                default: hit = !busy;
            endcase
        end
        if (!hit) checkOutput({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ex_start"}, 64'(ex_start), 64'(0));
        checkOutput({tag, "_mem_valid"}, 64'(mem_valid), 64'(0));
        checkOutput({tag, "_redirect"}, 64'(redirect), 64'(0));
        checkOutput({tag, "_error"}, 64'(error), 64'(0));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
        checkOutput({tag, "_id_ready"}, 64'(id_ready), 64'(1));
        checkOutput({tag, "_ex_pc"}, 64'(ex_pc), 64'(0));
        checkOutput({tag, "_ex_rs1"}, 64'(ex_rs1), 64'(0));
        checkOutput({tag, "_ex_control"}, 64'(ex_control), 64'(control_s_default()));
        checkOutput({tag, "_mem_rd"}, 64'(mem_rd_output), 64'(0));
        checkOutput({tag, "_mem_control"}, 64'(mem_control), 64'(control_s_default()));
        checkOutput({tag, "_redirect_pc"}, 64'(redirect_pc), 64'(0));
    endtask

    initial begin
        control_s add_c, br_c;
        int       n;

        reset = 1'b1; id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_imm = '0;
        id_control = control_s_default(); ex_done = 1'b0; ex_rd_output = '0; ex_pc_ext = '0;
        ex_pc_load = 1'b0; mem_ready = 1'b0;
        exec_lat = 1; rand_lat = 0; hold_done = 0; spurious_en = 0;
        add_c = control_s_default(); add_c.reg_write = 1'b1; add_c.rd = 5'd3;
        br_c  = control_s_default(); br_c.branch = 1'b1;

        step(); step();
        reset = 1'b0;
        checkResetState("por");

        // Single ADD
        applyStimulus(32'h100, 32'd5, 32'd7, 32'd0, add_c);
        waitFor(0, "add_start", n);
        checkOutput("add_start_latency", 64'(n), 64'(2));
        waitFor(1, "add_mem", n);
        checkOutput("add_rd", 64'(mem_rd_output), 64'(12));
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checkOutput("add_busy_idle", 64'(busy), 64'(0));

        // Back-pressure: three instructions while MEM stalls
        mem_log.delete();
        for (int i = 0; i < 3; i++) applyStimulus(32'h100 + 32'(4 * i), 32'h100 + 32'(4 * i), 32'd1, 32'd0, add_c);
        repeat (6) step();
        checkOutput("bp_id_ready_low", 64'(id_ready), 64'(0));
        mem_ready = 1'b1;
        waitFor(2, "bp_drain", n);
        mem_ready = 1'b0;
        checkOutput("bp_count", 64'(mem_log.size()), 64'(3));
        for (int i = 0; i < 3 && i < mem_log.size(); i++)
            checkOutput("bp_order", 64'(mem_log[i]), 64'(32'h101 + 32'(4 * i)));

        // Taken branch with two younger instructions buffered
        mem_ready = 1'b1; exec_lat = 4; redirect_count = 0; issued_pcs.delete();
        applyStimulus(32'h1F0, 32'd3, 32'd3, 32'h10, br_c);
        applyStimulus(32'h300, 32'd1, 32'd2, 32'd0, add_c);
        applyStimulus(32'h304, 32'd1, 32'd2, 32'd0, add_c);
        waitFor(2, "br_drain", n);
        checkOutput("br_redirect_count", 64'(redirect_count), 64'(1));
        checkOutput("br_redirect_pc", 64'(last_redirect_pc), 64'(32'h200));
        checkOutput("br_issued_count", 64'(issued_pcs.size()), 64'(1));

        // Flush in the same cycle as a push
        exec_lat = 2; redirect_count = 0; issued_pcs.delete();
        applyStimulus(32'h400, 32'd0, 32'd0, 32'h40, br_c);
        for (int i = 0; i < 40 && !(ex_done && waiting); i++) step();
        checkOutput("fp_done_seen", 64'(ex_done && waiting), 64'(1));
        checkOutput("fp_ready", 64'(id_ready), 64'(1));
        id_valid = 1'b1; id_pc = 32'h500; id_rs1 = 32'd9; id_rs2 = 32'd9; id_imm = '0; id_control = add_c;
        step();
        id_valid = 1'b0;
        waitFor(2, "fp_drain", n);
        repeat (4) step();
        checkOutput("fp_issued_count", 64'(issued_pcs.size()), 64'(1));
        checkOutput("fp_redirect_count", 64'(redirect_count), 64'(1));
        checkOutput("fp_busy", 64'(busy), 64'(0));

        // Watchdog
        hold_done = 1;
        applyStimulus(32'h600, 32'd1, 32'd1, 32'd0, add_c);
        waitFor(0, "wd_start", n);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == TIMEOUT - 1) checkOutput("wd_before", 64'(error), 64'(0));
            if (k == TIMEOUT)     checkOutput("wd_at", 64'(error), 64'(1));
            if (k == 20)          checkOutput("wd_sticky", 64'(error), 64'(1));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        hold_done = 0;
        checkResetState("wd_reset");

        // Reset during WAIT_DONE (branch in flight) and during HOLD
        exec_lat = 6; redirect_count = 0;
        applyStimulus(32'h700, 32'd1, 32'd1, 32'h8, br_c);
        waitFor(0, "rw_start", n);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkResetState("rst_wait");
        repeat (8) step();
        checkOutput("rst_wait_no_redirect", 64'(redirect_count), 64'(0));

        exec_lat = 1; mem_ready = 1'b0;
        applyStimulus(32'h800, 32'd2, 32'd2, 32'd0, add_c);
        applyStimulus(32'h804, 32'd2, 32'd2, 32'd0, add_c);
        waitFor(1, "rh_mem", n);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkResetState("rst_hold");
        repeat (4) step();
        checkOutput("rst_hold_idle", 64'(busy), 64'(0));

        // Randomised traffic
        rand_lat = 1; spurious_en = 1;
        for (int i = 0; i < 400; i++) begin
            id_valid   = 1'($urandom);
            id_pc      = $urandom & 32'hFFFF_FFFC;
            id_rs1     = $urandom;
            id_rs2     = $urandom;
            id_imm     = $urandom;
            id_control = rand_ctrl();
            mem_ready  = ($urandom_range(0, 9) < 6);
            step();
        end
        id_valid = 1'b0; mem_ready = 1'b1;
        waitFor(2, "rand_drain", n);
        checkOutput("rand_queue_empty", 64'(fifo_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
